// File: rtl/sonar_pkg.sv
// Shared sonar definitions: echo_timer FSM states, result status codes, field widths.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BLANK  = 3'd1,
        LISTEN = 3'd2,
        PEAK   = 3'd3,
        REPORT = 3'd4
    } state_t;

    localparam logic STATUS_ECHO    = 1'b0;
    localparam logic STATUS_TIMEOUT = 1'b1;

    localparam int unsigned TIME_W   = 32;
    localparam int unsigned MISSED_W = 8;

endpackage

// File: rtl/echo_timer_if.sv
// Echo result bus: time-of-flight, peak magnitude and status with valid/ready handshake.
interface echo_timer_if #(
    parameter int unsigned SAMPLE_W = 12
);
    import sonar_pkg::*;

    logic                m_valid;
    logic [TIME_W-1:0]   m_tof;
    logic [SAMPLE_W-1:0] m_peak;
    logic                m_status;
    logic                m_ready;

    modport master (
        output m_valid, m_tof, m_peak, m_status,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_tof, m_peak, m_status,
        output m_ready
    );

endinterface

// File: rtl/echo_abs.sv
// Combinational magnitude of a signed sample; the most-negative code saturates to max positive.
module echo_abs #(
    parameter int unsigned SAMPLE_W = 12
) (
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic        [SAMPLE_W-1:0] mag
);

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAX_POS  = ~MOST_NEG;

    // two's-complement negate for negatives, with the one code that has no positive twin clamped
    always_comb begin
        if (sample == MOST_NEG) begin
            mag = MAX_POS;
        end else if (sample[SAMPLE_W-1]) begin
            mag = SAMPLE_W'(~sample + 1'b1);
        end else begin
            mag = sample;
        end
    end

endmodule

// File: rtl/echo_timer.sv
// Sonar echo timer: times the first threshold crossing after a transmit strobe, past a blanking
// interval, and reports time-of-flight (or a timeout) over a valid/ready result bus.
// Build option ECHO_TIMER_PEAK_EN: when defined, a peak search over PEAK_WIN accepted samples
// follows detection; when undefined, detection reports directly and m_peak reads 0.
// PEAK_WIN must be at least 1.
module echo_timer
    import sonar_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned PEAK_WIN = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tx_start,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [SAMPLE_W-1:0] threshold,
    input  logic        [TIME_W-1:0]   blank_len,
    input  logic        [TIME_W-1:0]   timeout,
    echo_timer_if.master               result,
    output logic                       busy,
    output logic        [MISSED_W-1:0] missed_cnt
);

`ifdef ECHO_TIMER_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    localparam int unsigned WIN_W = $clog2(PEAK_WIN + 1);

    state_t              state, state_d;
    logic [TIME_W-1:0]   elapsed, elapsed_d, elapsed_inc;
    logic [TIME_W-1:0]   tof, tof_d;
    logic [SAMPLE_W-1:0] peak, peak_d, mag;
    logic                status, status_d;
    logic [WIN_W-1:0]    win_cnt, win_d;
    logic [MISSED_W-1:0] missed_d;
    logic                hit;

    echo_abs #(.SAMPLE_W(SAMPLE_W)) u_abs (
        .sample (sample),
        .mag    (mag)
    );

    // next-state and datapath update
    always_comb begin
        state_d     = state;
        elapsed_d   = elapsed;
        tof_d       = tof;
        peak_d      = peak;
        status_d    = status;
        win_d       = win_cnt;
        missed_d    = missed_cnt;
        elapsed_inc = (elapsed == '1) ? elapsed : elapsed + 1'b1;
        hit         = sample_valid && (mag >= threshold);

        case (state)
            IDLE: begin
                // the strobe cycle itself is elapsed 0, so the first BLANK cycle reads 1
                if (tx_start) begin
                    state_d   = BLANK;
                    elapsed_d = TIME_W'(1);
                end
            end
            BLANK, LISTEN: begin
                elapsed_d = elapsed_inc;
                if (elapsed >= timeout) begin
                    state_d  = REPORT;
                    tof_d    = timeout;
                    peak_d   = '0;
                    status_d = STATUS_TIMEOUT;
                end else if (state == BLANK) begin
                    if (elapsed >= blank_len) begin
                        state_d = LISTEN;
                    end
                end else if (hit) begin
                    tof_d    = elapsed;
                    peak_d   = mag;
                    status_d = STATUS_ECHO;
                    win_d    = '0;
                    state_d  = PEAK_EN ? PEAK : REPORT;
                end
            end
            PEAK: begin
                elapsed_d = elapsed_inc;
                if (sample_valid) begin
                    if (mag > peak) begin
                        peak_d = mag;
                    end
                    win_d = win_cnt + 1'b1;
                    if (win_cnt == WIN_W'(PEAK_WIN - 1)) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (tx_start && (missed_cnt != '1)) begin
                    missed_d = missed_cnt + 1'b1;
                end
                if (result.m_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // a new strobe during a measurement abandons it and starts over
        if (tx_start && ((state == BLANK) || (state == LISTEN) || (state == PEAK))) begin
            state_d   = BLANK;
            elapsed_d = TIME_W'(1);
            peak_d    = '0;
            win_d     = '0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            elapsed    <= '0;
            tof        <= '0;
            peak       <= '0;
            status     <= STATUS_ECHO;
            win_cnt    <= '0;
            missed_cnt <= '0;
        end else begin
            state      <= state_d;
            elapsed    <= elapsed_d;
            tof        <= tof_d;
            peak       <= peak_d;
            status     <= status_d;
            win_cnt    <= win_d;
            missed_cnt <= missed_d;
        end
    end

    assign result.m_valid  = (state == REPORT);
    assign result.m_tof    = tof;
    assign result.m_peak   = PEAK_EN ? peak : '0;
    assign result.m_status = status;
    assign busy            = (state != IDLE);

endmodule

// File: tb/tb_echo_timer.sv
// Self-checking bench for echo_timer: directed vector table, hand-written multi-cycle sequences,
// and randomized bursts scored against a per-burst reference model.
module tb_echo_timer;

    localparam int unsigned SW   = 12;
    localparam int unsigned PW   = 16;
    localparam int          MAXE = 2400;
    localparam int          MAXM = (1 << (SW - 1)) - 1;
`ifdef ECHO_TIMER_PEAK_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 tx_start;
    logic                 sample_valid;
    logic signed [SW-1:0] sample;
    logic [SW-1:0]        threshold;
    logic [31:0]          blank_len;
    logic [31:0]          timeout;
    logic                 busy;
    logic [7:0]           missed_cnt;

    echo_timer_if #(.SAMPLE_W(SW)) res_if ();

    echo_timer #(.SAMPLE_W(SW), .PEAK_WIN(PW)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .threshold    (threshold),
        .blank_len    (blank_len),
        .timeout      (timeout),
        .result       (res_if),
        .busy         (busy),
        .missed_cnt   (missed_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit sv [MAXE];
    int sd [MAXE];

    typedef struct {
        int bl; int to; int thr; int pat;
        int tof; int peak_pk; int st;
    } vec_t;
    vec_t vt [8];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mag_of(input int s);
        int m;
        m = (s < 0) ? -s : s;
        if (m > MAXM) m = MAXM;
        return m;
    endfunction

    task automatic clear_samples();
        for (int e = 0; e < MAXE; e++) begin
            sv[e] = 1'b0;
            sd[e] = 0;
        end
    endtask

    task automatic fill_run(input int from, input int to_e, input int val);
        for (int e = from; e <= to_e; e++) begin
            sv[e] = 1'b1;
            sd[e] = val;
        end
    endtask

    // Reference: from the sample stream indexed by elapsed time, work out the result and
    // the elapsed cycle in which m_valid first shows.
    task automatic predict(input int bl, input int to, input int thr,
                           output int rep, output int tof, output int peak, output int st);
        int t0, l0, det, n;
        t0 = (to < 1) ? 1 : to;
        l0 = ((bl < 1) ? 1 : bl) + 1;
        det = -1;
        for (int e = l0; e < t0 && e < MAXE; e++) begin
            if (sv[e] && mag_of(sd[e]) >= thr) begin
                det = e;
                break;
            end
        end
        if (det < 0) begin
            rep = t0 + 1; tof = to; peak = 0; st = 1;
        end else begin
            tof = det; st = 0; rep = det + 1; peak = 0;
            if (PK) begin
                peak = mag_of(sd[det]);
                n = 0;
                for (int e = det + 1; e < MAXE; e++) begin
                    if (sv[e]) begin
                        if (mag_of(sd[e]) > peak) peak = mag_of(sd[e]);
                        n++;
                        if (n == PW) begin
                            rep = e + 1;
                            break;
                        end
                    end
                end
            end
        end
    endtask

    // called just after a rising edge; leaves just after the following rising edge
    task automatic strobe();
        tx_start     = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk); #1;
        tx_start = 1'b0;
    endtask

    // plays samples from elapsed 1 until m_valid shows or the bound expires
    task automatic collect(input int bound, input bit ack,
                           output int rep, output int tof, output int peak, output int st);
        int  e;
        bit  found;
        e = 1; found = 1'b0; rep = -1; tof = 0; peak = 0; st = 0;
        while (!found && e <= bound && e < MAXE) begin
            sample_valid = sv[e];
            sample       = SW'(sd[e]);
            @(negedge clk);
            if (res_if.m_valid) begin
                found  = 1'b1;
                rep    = e;
                tof    = int'(res_if.m_tof);
                peak   = int'(res_if.m_peak);
                st     = int'(res_if.m_status);
                res_if.m_ready = ack;
            end
            @(posedge clk); #1;
            res_if.m_ready = 1'b0;
            sample_valid   = 1'b0;
            e++;
        end
    endtask

    task automatic run_burst(input string tag, input int bl, input int to, input int thr,
                             output int tof, output int peak, output int st,
                             output int mtof, output int mpeak, output int mst);
        int mrep, rep, bound;
        blank_len = 32'(bl);
        timeout   = 32'(to);
        threshold = SW'(thr);
        predict(bl, to, thr, mrep, mtof, mpeak, mst);
        bound = (mrep + 5 < MAXE - 1) ? mrep + 5 : MAXE - 1;
        strobe();
        collect(bound, 1'b1, rep, tof, peak, st);
        check({tag, "_latency"}, rep, mrep);
        @(negedge clk);
        check({tag, "_idle_after_ack"}, {res_if.m_valid, busy}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit hit, expected completion");
        $fatal(1);
    end

    initial begin
        int tof, peak, st, mtof, mpeak, mst, rep, mrep, unstable;
        int bl, to, thr;

        vt[0] = '{bl: 100, to: 10000, thr: 500,  pat: 0, tof: 250,  peak_pk: 900,  st: 0};
        vt[1] = '{bl: 100, to: 2000,  thr: 500,  pat: 1, tof: 2000, peak_pk: 0,    st: 1};
        vt[2] = '{bl: 5,   to: 100,   thr: 2047, pat: 2, tof: 10,   peak_pk: 2047, st: 0};
        vt[3] = '{bl: 20,  to: 100,   thr: 0,    pat: 3, tof: 21,   peak_pk: 3,    st: 0};
        vt[4] = '{bl: 200, to: 150,   thr: 500,  pat: 4, tof: 150,  peak_pk: 0,    st: 1};
        vt[5] = '{bl: 0,   to: 50,    thr: 500,  pat: 4, tof: 2,    peak_pk: 1000, st: 0};
        vt[6] = '{bl: 10,  to: 40,    thr: 500,  pat: 5, tof: 40,   peak_pk: 0,    st: 1};
        vt[7] = '{bl: 10,  to: 40,    thr: 500,  pat: 6, tof: 39,   peak_pk: 900,  st: 0};

        rst = 1'b1; tx_start = 1'b0; sample_valid = 1'b0; sample = '0;
        threshold = '0; blank_len = '0; timeout = '0; res_if.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", res_if.m_valid, 0);
        check("rst_m_tof", res_if.m_tof, 0);
        check("rst_m_peak", res_if.m_peak, 0);
        check("rst_m_status", res_if.m_status, 0);
        check("rst_busy", busy, 0);
        check("rst_missed", missed_cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // directed vector table
        for (int i = 0; i < 8; i++) begin
            clear_samples();
            case (vt[i].pat)
                0: begin
                    sv[200] = 1'b1; sd[200] = 499;
                    sv[250] = 1'b1; sd[250] = 600;
                    fill_run(251, 300, 100);
                    sv[252] = 1'b0; sd[252] = 2000;
                    sd[253] = -900;
                    sd[268] = 1500;
                end
                1: begin sv[50] = 1'b1; sd[50] = 800; end
                2: begin fill_run(11, 40, 5); sv[10] = 1'b1; sd[10] = -2048; end
                3: fill_run(1, MAXE - 1, 3);
                4: fill_run(1, MAXE - 1, 1000);
                5: begin sv[40] = 1'b1; sd[40] = 900; end
                default: begin fill_run(40, 70, 10); sv[39] = 1'b1; sd[39] = 900; end
            endcase
            run_burst($sformatf("vec%0d", i), vt[i].bl, vt[i].to, vt[i].thr,
                      tof, peak, st, mtof, mpeak, mst);
            check($sformatf("vec%0d_tof", i), tof, vt[i].tof);
            check($sformatf("vec%0d_peak", i), peak, PK ? vt[i].peak_pk : 0);
            check($sformatf("vec%0d_status", i), st, vt[i].st);
        end

        // restart: a second strobe at elapsed 300 in LISTEN re-bases time-of-flight
        clear_samples();
        sv[150] = 1'b1; sd[150] = 700;
        fill_run(151, 200, 20);
        blank_len = 32'd100; timeout = 32'd1000; threshold = SW'(500);
        predict(100, 1000, 500, mrep, mtof, mpeak, mst);
        strobe();
        for (int c = 1; c < 300; c++) begin
            @(posedge clk); #1;
        end
        strobe();
        collect(mrep + 5, 1'b1, rep, tof, peak, st);
        check("restart_latency", rep, mrep);
        check("restart_tof", tof, 150);
        check("restart_peak", peak, PK ? 700 : 0);
        check("restart_status", st, 0);
        @(posedge clk); #1;

        // result held 20 cycles with m_ready low while three strobes are dropped
        clear_samples();
        sv[30] = 1'b1; sd[30] = 1000;
        fill_run(31, 60, 1);
        blank_len = 32'd10; timeout = 32'd500; threshold = SW'(500);
        predict(10, 500, 500, mrep, mtof, mpeak, mst);
        strobe();
        collect(mrep + 5, 1'b0, rep, tof, peak, st);
        check("hold_latency", rep, mrep);
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            tx_start = (k == 3) || (k == 9) || (k == 15);
            @(negedge clk);
            if (!res_if.m_valid || res_if.m_tof != 32'd30 || res_if.m_status != 1'b0
                || int'(res_if.m_peak) != (PK ? 1000 : 0)) unstable++;
            @(posedge clk); #1;
            tx_start = 1'b0;
        end
        check("hold_unstable_cycles", unstable, 0);
        check("hold_missed", missed_cnt, 3);
        // strobe coincident with the handshake is dropped as well
        tx_start = 1'b1; res_if.m_ready = 1'b1;
        @(negedge clk);
        check("hs_valid", res_if.m_valid, 1);
        @(posedge clk); #1;
        tx_start = 1'b0; res_if.m_ready = 1'b0;
        @(negedge clk);
        check("hs_then_idle", busy, 0);
        check("hs_missed", missed_cnt, 4);
        @(posedge clk); #1;

        // missed counter saturation, then reset while a result is on the bus
        strobe();
        collect(mrep + 5, 1'b0, rep, tof, peak, st);
        check("sat_latency", rep, mrep);
        tx_start = 1'b1;
        repeat (260) begin
            @(posedge clk); #1;
        end
        tx_start = 1'b0;
        @(negedge clk);
        check("sat_missed", missed_cnt, 255);
        check("sat_still_valid", res_if.m_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstrep_valid", res_if.m_valid, 0);
        check("rstrep_tof", res_if.m_tof, 0);
        check("rstrep_peak", res_if.m_peak, 0);
        check("rstrep_status", res_if.m_status, 0);
        check("rstrep_busy", busy, 0);
        check("rstrep_missed", missed_cnt, 0);
        @(posedge clk); #1;

        // reset one cycle after detection (peak search, or report without it)
        clear_samples();
        sv[20] = 1'b1; sd[20] = 800;
        fill_run(21, 60, 5);
        blank_len = 32'd5; timeout = 32'd100; threshold = SW'(500);
        strobe();
        for (int e = 1; e <= 20; e++) begin
            sample_valid = sv[e]; sample = SW'(sd[e]);
            @(posedge clk); #1;
        end
        sample_valid = 1'b1; sample = SW'(5);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; sample_valid = 1'b0;
        @(negedge clk);
        check("rstpk_valid", res_if.m_valid, 0);
        check("rstpk_tof", res_if.m_tof, 0);
        check("rstpk_peak", res_if.m_peak, 0);
        check("rstpk_status", res_if.m_status, 0);
        check("rstpk_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstpk_stays_idle", busy, 0);
        @(posedge clk); #1;

        // randomized bursts against the reference model
        for (int r = 0; r < 40; r++) begin
            bl  = int'($urandom_range(0, 80));
            to  = int'($urandom_range(0, 300));
            thr = int'($urandom_range(0, 2047));
            for (int e = 0; e < MAXE; e++) begin
                sv[e] = ($urandom_range(0, 1) == 1);
                sd[e] = int'($urandom_range(0, 4095)) - 2048;
            end
            run_burst($sformatf("rnd%0d", r), bl, to, thr, tof, peak, st, mtof, mpeak, mst);
            check($sformatf("rnd%0d_tof", r), tof, mtof);
            check($sformatf("rnd%0d_peak", r), peak, mpeak);
            check($sformatf("rnd%0d_status", r), st, mst);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
